ysyx_22051145_ifq: RTL and testbench
====================================

# ysyx_22051145_ifq

Instruction fetch queue sitting directly downstream of the PC generator (`ysyx_22051145_ifu`) and upstream of the IDU. It accepts fetch PCs, issues in-order read requests to instruction memory, and holds up to `DEPTH` PC/instruction pairs. It delivers those pairs to decode over a valid/ready handshake. On a redirect (`flush`), it discards all queued and in-flight fetches.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_valid` in 1: upstream PC valid.
- `pc` in 64: fetch address.
- `pc_ready` out 1: PC accepted this cycle when `pc_valid && pc_ready`.
- `imem_req_valid` out 1: memory read request.
- `imem_req_addr` out 64: request address (equal to `pc`).
- `imem_req_ready` in 1: memory accepts request.
- `imem_resp_valid` in 1: read data returned; in order, ≥1 cycle after request accept.
- `imem_resp_data` in 32: instruction word.
- `flush` in 1: redirect (jump taken); kill everything.
- `inst_valid` out 1: head entry complete.
- `inst_pc` out 64: PC of head entry.
- `inst` out 32: instruction of head entry.
- `inst_ready` in 1: IDU consumes head when `inst_valid && inst_ready`.

## Operation
- Entry state: `{vld, done, pc[63:0], inst[31:0]}`. Pointers: `wr_ptr`, `rsp_ptr`, `rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy `cnt` is log2(DEPTH)+1 bits.
- **Issue.**
  - `credit = (cnt < DEPTH)`.
  - `imem_req_valid = pc_valid && credit && !flush && !rst`.
  - `pc_ready = imem_req_ready && credit && !flush && !rst`.
  - `imem_req_addr = pc`.
  - Handshake fire allocates the entry at `wr_ptr` (`vld=1`, `done=0`, pc stored) and increments `wr_ptr`.
- **Response.**
  - While `drop_cnt != 0`, each `imem_resp_valid` decrements `drop_cnt` and the data is discarded.
  - Otherwise the response writes `inst` into the `rsp_ptr` entry, sets `done=1`, and increments `rsp_ptr`.
  - A response with no outstanding request (`rsp_ptr == wr_ptr` and `drop_cnt == 0`) is ignored.
- **Deliver.**
  - `inst_valid = vld[rd_ptr] && done[rd_ptr] && !flush`.
  - Pop clears `vld` and increments `rd_ptr`.
  - `cnt` changes by (+1 on issue) (−1 on pop); simultaneous issue and pop leaves it unchanged.
- **Flush.**
  - All `vld`/`done` are cleared.
  - `wr_ptr`, `rsp_ptr`, and `rd_ptr` are set to 0; `cnt` is set to 0.
  - `drop_cnt` ← `drop_cnt + (wr_ptr − rsp_ptr) − (imem_resp_valid ? 1 : 0)`, floored at 0. Any response arriving in the flush cycle is discarded. `drop_cnt` width is log2(DEPTH)+2.
  - No issue and no pop occur in the flush cycle.
- Issue is allowed while `drop_cnt != 0`. Ordering guarantees that the first `drop_cnt` responses belong to killed requests.

## Timing
- **Reset.** The cycle `rst` is high, and the state after it:
  - `pc_ready=0`, `imem_req_valid=0`, `inst_valid=0`.
  - `inst=0`, `inst_pc=0`.
  - All pointers, `cnt`, and `drop_cnt` are 0; all `vld`/`done` are 0.
  - Reset mid-operation abandons outstanding requests without drop tracking. The memory side is reset by the same `rst`.
- **Latency.** Request accepted at cycle T and response at T+k:
  - Without bypass: `inst_valid` at T+k+1, provided the entry is at the head.
  - With `IFQ_BYPASS_EN`: see Configuration.
- **Throughput.** One issue, one response, and one pop per cycle are all possible in the same cycle.
- **Full.** When `cnt == DEPTH`, `pc_ready=0`. A pop in the same cycle does not free the credit until the next cycle, because `credit` uses registered `cnt`.
- **Empty.** When the head is not `done`, `inst_valid=0`, and `inst`/`inst_pc` hold their last values.
- **Wrap.** Pointers wrap from DEPTH−1 to 0. Entry order is preserved across the wrap.

## Configuration
- `YSYX_22051145_IFQ_BYPASS_EN` defined:
  - If the head entry is `vld && !done`, `drop_cnt == 0`, and `imem_resp_valid` is high, then `inst_valid=1`, `inst=imem_resp_data`, and `inst_pc` is the head pc in that same cycle.
  - If `inst_ready` is also high, the entry is popped without being written `done`. Latency is T+k.
- Undefined: no combinational path from `imem_resp_*` to `inst_*`. Latency is T+k+1.

## Test plan
- **Streaming.** Reset; `pc_valid=1`, pc 0x80000000, +4 each cycle; memory with 1-cycle latency; `inst_ready=1`.
  - Expect `inst_pc` 0x80000000, 0x80000004, … on consecutive cycles.
  - First `inst_valid` 2 cycles after the first accept (1 cycle with bypass).
- **Full backpressure.** `inst_ready=0`, DEPTH=4, 4 PCs issued and answered.
  - `pc_ready` drops to 0 after the 4th accept.
  - Raising `inst_ready` delivers all 4 in order; `pc_ready` returns the cycle after the first pop.
- **Flush with in-flight requests.** 3 requests outstanding, `flush` asserted, new pc 0x80000100 issued next cycle.
  - The next 3 responses are dropped.
  - The 4th response appears with `inst_pc=0x80000100`.
- **Flush colliding with a response.** 2 outstanding; `flush` in the same cycle as one response.
  - That response and exactly one more are discarded.
  - `inst_valid=0` in the flush cycle.
- **Wrap-around.** 10 sequential fetches with a random 1–3 cycle memory latency and random `inst_ready`.
  - All 10 are delivered in order with no duplication.
  - Pointers wrap twice.
- **Reset mid-operation.** `rst` pulsed with 2 entries queued and 1 in flight.
  - The next cycle has `inst_valid=0`, `cnt=0`, and `drop_cnt=0`.
  - A fresh fetch of 0x80000000 completes normally.

Source files
------------

// File: rtl/ysyx_22051145_ifq_if.sv
// Bundle of every signal between the fetch queue and its neighbours:
// the PC generator, instruction memory and the decoder, plus a read-only
// debug view of the queue bookkeeping.
//
// Handshake rule for pc_valid/pc_ready, imem_req_valid/imem_req_ready and
// inst_valid/inst_ready: a transfer happens on the rising clock edge where
// both valid and ready are high.
// Instruction memory answers in request order with imem_resp_valid, no
// earlier than one cycle after the request transfer. It has no ready signal.
interface ysyx_22051145_ifq_if #(
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH);

  logic          pc_valid;
  logic [63:0]   pc;
  logic          pc_ready;

  logic          imem_req_valid;
  logic [63:0]   imem_req_addr;
  logic          imem_req_ready;

  logic          imem_resp_valid;
  logic [31:0]   imem_resp_data;

  logic          flush;

  logic          inst_valid;
  logic [63:0]   inst_pc;
  logic [31:0]   inst;
  logic          inst_ready;

  logic [PW:0]   dbg_cnt;
  logic [PW+1:0] dbg_drop_cnt;
  logic [PW-1:0] dbg_wr_ptr;
  logic [PW-1:0] dbg_rsp_ptr;
  logic [PW-1:0] dbg_rd_ptr;

  // The fetch queue side.
  modport slave (
    input  pc_valid, pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           flush, inst_ready,
    output pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
           dbg_cnt, dbg_drop_cnt, dbg_wr_ptr, dbg_rsp_ptr, dbg_rd_ptr
  );

  // The environment side: PC generator, memory and decoder together.
  modport master (
    output pc_valid, pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           flush, inst_ready,
    input  pc_ready, imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst,
           dbg_cnt, dbg_drop_cnt, dbg_wr_ptr, dbg_rsp_ptr, dbg_rd_ptr
  );
endinterface

// File: rtl/ysyx_22051145_ifq.sv
// Instruction fetch queue between the PC generator and decode.
// Accepts fetch PCs, issues in-order memory reads, and holds up to DEPTH
// PC/instruction pairs for decode. A flush kills every queued entry and
// counts still-outstanding reads so that their responses are dropped.
//
// Optional feature macro: YSYX_22051145_IFQ_BYPASS_EN
//   defined   - a response for a waiting head entry is presented to decode
//               in the same cycle it arrives.
//   undefined - decode only sees entries that were written the cycle before.
module ysyx_22051145_ifq #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22051145_ifq_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = PW + 2;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] done_q;
  logic [63:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rsp_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    drop_cnt;
  logic [63:0]      hold_pc;
  logic [31:0]      hold_inst;

  logic             credit;
  logic             issue;
  logic             resp_ok;
  logic             head_done;
  logic             bypass;
  logic             pop;
  logic [63:0]      head_pc;
  logic [31:0]      head_inst;
  logic [CW-1:0]    outstanding;
  logic [DW:0]      drop_sum;
  logic [DW-1:0]    drop_nxt;

  // Credit comes from the registered count, so a pop frees a slot only
  // from the following cycle.
  assign credit             = (cnt < CW'(DEPTH));
  assign bus.imem_req_valid = bus.pc_valid && credit && !bus.flush && !rst;
  assign bus.pc_ready       = bus.imem_req_ready && credit && !bus.flush && !rst;
  assign bus.imem_req_addr  = bus.pc;
  assign issue              = bus.pc_valid && bus.pc_ready;

  // A response belongs to the entry at rsp_ptr when nothing is pending a
  // drop and that entry is still waiting; otherwise it is stray and ignored.
  assign resp_ok = bus.imem_resp_valid && (drop_cnt == '0) &&
                   vld_q[rsp_ptr] && !done_q[rsp_ptr] && !bus.flush && !rst;

  assign head_done = vld_q[rd_ptr] && done_q[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

`ifdef YSYX_22051145_IFQ_BYPASS_EN
  // A waiting head is always the oldest outstanding read, so a live
  // response is the head's instruction.
  assign bypass    = vld_q[rd_ptr] && !done_q[rd_ptr] && (drop_cnt == '0) &&
                     bus.imem_resp_valid;
  assign head_inst = head_done ? inst_mem[rd_ptr] : bus.imem_resp_data;
`else
  assign bypass    = 1'b0;
  assign head_inst = inst_mem[rd_ptr];
`endif

  assign bus.inst_valid = (head_done || bypass) && !bus.flush && !rst;
  assign pop            = bus.inst_valid && bus.inst_ready;

  // Outputs hold the last delivered pair while the head is not ready.
  assign bus.inst_pc = rst ? 64'd0 : (bus.inst_valid ? head_pc   : hold_pc);
  assign bus.inst    = rst ? 32'd0 : (bus.inst_valid ? head_inst : hold_inst);

  assign bus.dbg_cnt      = cnt;
  assign bus.dbg_drop_cnt = drop_cnt;
  assign bus.dbg_wr_ptr   = wr_ptr;
  assign bus.dbg_rsp_ptr  = rsp_ptr;
  assign bus.dbg_rd_ptr   = rd_ptr;

  // Drop count after a flush: reads still in flight, minus any response
  // landing in the flush cycle itself, never below zero.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < DEPTH; i++) begin
      outstanding = outstanding + {{(CW-1){1'b0}}, (vld_q[i] & ~done_q[i])};
    end
    drop_sum = {1'b0, drop_cnt} + {{(DW+1-CW){1'b0}}, outstanding};
    if (bus.imem_resp_valid && (drop_sum != '0)) begin
      drop_sum = drop_sum - (DW+1)'(1);
    end
    drop_nxt = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
  end

  // Pointers, occupancy and the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rsp_ptr  <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= drop_nxt;
    end else begin
      if (issue)   wr_ptr  <= wr_ptr + PW'(1);
      if (resp_ok) rsp_ptr <= rsp_ptr + PW'(1);
      if (pop)     rd_ptr  <= rd_ptr + PW'(1);
      case ({issue, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.imem_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
    end
  end

  // Per-entry valid/done flags; a pop is applied last so a bypassed
  // response never leaves its popped entry marked done.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      vld_q  <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && (wr_ptr == PW'(i))) begin
          vld_q[i]  <= 1'b1;
          done_q[i] <= 1'b0;
        end
        if (resp_ok && (rsp_ptr == PW'(i))) begin
          done_q[i] <= 1'b1;
        end
        if (pop && (rd_ptr == PW'(i))) begin
          vld_q[i]  <= 1'b0;
          done_q[i] <= 1'b0;
        end
      end
    end
  end

  // Entry payload storage; only read while the matching flags say valid.
  always_ff @(posedge clk) begin
    if (issue)   pc_mem[wr_ptr]    <= bus.pc;
    if (resp_ok) inst_mem[rsp_ptr] <= bus.imem_resp_data;
  end

  // Last delivered pair, shown while decode has nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc   <= '0;
      hold_inst <= '0;
    end else if (bus.inst_valid) begin
      hold_pc   <= head_pc;
      hold_inst <= head_inst;
    end
  end
endmodule

// File: tb/tb_ysyx_22051145_ifq.sv
// Directed bench for the fetch queue: reset, streaming, full backpressure,
// flush with in-flight reads, flush colliding with a response, pointer
// wrap and reset mid-operation. An in-order memory model answers requests.
module tb_ysyx_22051145_ifq;
  localparam int DEPTH = 4;
`ifdef YSYX_22051145_IFQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22051145_ifq_if #(.DEPTH(DEPTH)) bus ();
  ysyx_22051145_ifq #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- stimulus state ----------------
  logic        rst_r;
  logic        pc_valid_r;
  logic [63:0] pc_r;
  logic        flush_r;
  logic        inst_ready_r;
  logic        req_ready_r;
  int          mem_lat;
  logic        rand_lat;

  // ---------------- scoreboard / memory model ----------------
  logic [63:0] exp_q[$];
  logic [63:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due;
  int          cyc;
  int          acc_cnt;
  int          pop_cnt;
  int          first_acc_cyc;
  int          first_vld_cyc;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive inputs after the falling edge, then observe what the
  // coming rising edge will commit.
  task automatic step();
    logic [63:0] e;
    int          due;
    @(negedge clk);
    cyc++;
    rst = rst_r;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (rst_r) begin
      mem_addr_q.delete();
      mem_due_q.delete();
      last_due = 0;
    end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    bus.pc_valid       = pc_valid_r;
    bus.pc             = pc_r;
    bus.flush          = flush_r;
    bus.inst_ready     = inst_ready_r;
    bus.imem_req_ready = req_ready_r;
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      due = cyc + (rand_lat ? int'($urandom_range(1, 3)) : mem_lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(bus.imem_req_addr);
      mem_due_q.push_back(due);
    end
    if (bus.pc_valid && bus.pc_ready) begin
      exp_q.push_back(pc_r);
      acc_cnt++;
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      pc_r = pc_r + 64'd4;
    end
    if (bus.inst_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (bus.inst_valid && bus.inst_ready) begin
      pop_cnt++;
      check("pop_has_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_pc", bus.inst_pc, e);
        check("inst", {32'd0, bus.inst}, {32'd0, mem_word(e)});
      end
    end
    if (flush_r || rst_r) exp_q.delete();
  endtask

  task automatic clear_counts();
    acc_cnt       = 0;
    pop_cnt       = 0;
    first_acc_cyc = -1;
    first_vld_cyc = -1;
  endtask

  task automatic reset_dut();
    rst_r      = 1'b1;
    pc_valid_r = 1'b0;
    flush_r    = 1'b0;
    step();
    step();
    rst_r = 1'b0;
    clear_counts();
  endtask

  task automatic issue_n(input int n, input string tag);
    int target;
    int k;
    target = acc_cnt + n;
    k = 0;
    pc_valid_r = 1'b1;
    while (acc_cnt < target && k < 100) begin
      step();
      k++;
    end
    pc_valid_r = 1'b0;
    check(tag, 64'(acc_cnt), 64'(target));
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    pc_valid_r   = 1'b0;
    flush_r      = 1'b0;
    inst_ready_r = 1'b1;
    while ((exp_q.size() != 0 || mem_addr_q.size() != 0) && k < 200) begin
      step();
      k++;
    end
    step();
    check(tag, 64'(exp_q.size() == 0 && mem_addr_q.size() == 0), 64'd1);
  endtask

  // Watchdog: a hung run still reports and stops.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- tests ----------------
  initial begin
    int k;
    n_checks = 0; n_fail = 0; cyc = 0; last_due = 0;
    rst_r = 1'b1; pc_valid_r = 1'b1; pc_r = 64'h8000_0000; flush_r = 1'b0;
    inst_ready_r = 1'b1; req_ready_r = 1'b1; mem_lat = 1; rand_lat = 1'b0;
    clear_counts();

    // Reset: outputs forced low even with pc_valid high.
    step();
    check("rst_pc_ready",   64'(bus.pc_ready), 64'd0);
    check("rst_req_valid",  64'(bus.imem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_inst_pc",    bus.inst_pc, 64'd0);
    check("rst_inst",       {32'd0, bus.inst}, 64'd0);
    step();
    rst_r = 1'b0; pc_valid_r = 1'b0;
    step();
    check("post_rst_cnt",   64'(bus.dbg_cnt), 64'd0);
    check("post_rst_drop",  64'(bus.dbg_drop_cnt), 64'd0);
    check("post_rst_wr",    64'(bus.dbg_wr_ptr), 64'd0);
    check("post_rst_valid", 64'(bus.inst_valid), 64'd0);
    check("post_rst_hold",  bus.inst_pc, 64'd0);

    // Streaming: one accept per cycle, 1-cycle memory, decode always ready.
    clear_counts();
    pc_r = 64'h8000_0000; mem_lat = 1; inst_ready_r = 1'b1; pc_valid_r = 1'b1;
    repeat (12) step();
    check("stream_acc",  64'(acc_cnt), 64'd12);
    check("stream_pops", 64'(pop_cnt), 64'(BYP ? 11 : 10));
    check("stream_lat",  64'(first_vld_cyc - first_acc_cyc), 64'(BYP ? 1 : 2));
    drain("stream_drain");
    check("stream_total", 64'(pop_cnt), 64'd12);
    check("stream_hold_pc", bus.inst_pc, 64'h8000_002c);

    // Full backpressure: four entries fill the queue.
    reset_dut();
    pc_r = 64'h8000_0000; mem_lat = 1; inst_ready_r = 1'b0; pc_valid_r = 1'b1;
    repeat (4) step();
    check("full_acc", 64'(acc_cnt), 64'd4);
    step();
    check("full_pc_ready", 64'(bus.pc_ready), 64'd0);
    check("full_cnt",      64'(bus.dbg_cnt), 64'd4);
    step();
    check("full_pc_ready2", 64'(bus.pc_ready), 64'd0);
    check("full_hold_valid", 64'(bus.inst_valid), 64'd1);
    pc_valid_r = 1'b0; inst_ready_r = 1'b1;
    step();
    check("full_pop_pc_ready", 64'(bus.pc_ready), 64'd0);
    check("full_pop_pc",       bus.inst_pc, 64'h8000_0000);
    step();
    check("full_credit_back", 64'(bus.pc_ready), 64'd1);
    drain("full_drain");
    check("full_pops", 64'(pop_cnt), 64'd4);

    // Flush with three reads in flight: their responses must be dropped.
    reset_dut();
    pc_r = 64'h8000_0000; mem_lat = 5; inst_ready_r = 1'b1;
    issue_n(3, "fl_issue");
    flush_r = 1'b1;
    step();
    check("fl_pc_ready",   64'(bus.pc_ready), 64'd0);
    check("fl_inst_valid", 64'(bus.inst_valid), 64'd0);
    flush_r = 1'b0;
    pc_r = 64'h8000_0100; pc_valid_r = 1'b1;
    step();
    pc_valid_r = 1'b0;
    check("fl_drop_cnt", 64'(bus.dbg_drop_cnt), 64'd3);
    check("fl_new_acc",  64'(acc_cnt), 64'd4);
    drain("fl_drain");
    check("fl_pops",     64'(pop_cnt), 64'd1);
    check("fl_drop_end", 64'(bus.dbg_drop_cnt), 64'd0);
    check("fl_last_pc",  bus.inst_pc, 64'h8000_0100);

    // Flush in the same cycle as a response: that one plus one more dropped.
    reset_dut();
    pc_r = 64'h8000_0000; mem_lat = 3; inst_ready_r = 1'b1;
    issue_n(2, "col_issue");
    step();
    flush_r = 1'b1;
    step();
    check("col_inst_valid", 64'(bus.inst_valid), 64'd0);
    flush_r = 1'b0;
    step();
    check("col_drop1", 64'(bus.dbg_drop_cnt), 64'd1);
    step();
    check("col_drop0", 64'(bus.dbg_drop_cnt), 64'd0);
    pc_r = 64'h8000_0200; mem_lat = 1;
    issue_n(1, "col_new_issue");
    drain("col_drain");
    check("col_pops", 64'(pop_cnt), 64'd1);

    // Wrap: ten fetches with random latency, request ready and decode ready.
    reset_dut();
    pc_r = 64'h8000_2000; rand_lat = 1'b1;
    k = 0;
    pc_valid_r = 1'b1;
    while (acc_cnt < 10 && k < 300) begin
      inst_ready_r = 1'($urandom_range(0, 1));
      req_ready_r  = ($urandom_range(0, 3) != 0);
      step();
      k++;
    end
    pc_valid_r = 1'b0; req_ready_r = 1'b1;
    check("wrap_acc", 64'(acc_cnt), 64'd10);
    drain("wrap_drain");
    rand_lat = 1'b0;
    check("wrap_pops",   64'(pop_cnt), 64'd10);
    check("wrap_wr_ptr", 64'(bus.dbg_wr_ptr), 64'd2);
    check("wrap_rsp_ptr", 64'(bus.dbg_rsp_ptr), 64'd2);
    check("wrap_rd_ptr", 64'(bus.dbg_rd_ptr), 64'd2);
    check("wrap_cnt",    64'(bus.dbg_cnt), 64'd0);

    // Reset mid-operation: two done entries and one read in flight.
    reset_dut();
    pc_r = 64'h8000_0000; mem_lat = 1; inst_ready_r = 1'b0;
    issue_n(2, "rm_issue");
    mem_lat = 6;
    issue_n(1, "rm_issue3");
    step();
    check("rm_cnt_before", 64'(bus.dbg_cnt), 64'd3);
    rst_r = 1'b1;
    step();
    check("rm_rst_valid",    64'(bus.inst_valid), 64'd0);
    check("rm_rst_pc_ready", 64'(bus.pc_ready), 64'd0);
    rst_r = 1'b0;
    step();
    check("rm_valid", 64'(bus.inst_valid), 64'd0);
    check("rm_cnt",   64'(bus.dbg_cnt), 64'd0);
    check("rm_drop",  64'(bus.dbg_drop_cnt), 64'd0);
    clear_counts();
    mem_lat = 1; inst_ready_r = 1'b1; pc_r = 64'h8000_0000;
    issue_n(1, "rm_fresh_issue");
    drain("rm_drain");
    check("rm_pops", 64'(pop_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
